// File: rtl/regfile_wb_pkg.sv
// Shared constants for the register file and its pending memory-write queue.
// The classic register-file macros are kept here so existing code that uses them still compiles.
`ifndef REGFILE_WB_DEFINES
`define REGFILE_WB_DEFINES
`define DATA_WIDTH    32
`define RADDR_WIDTH   5
`define REG_NUM       32
`define ZERO          32'd0
`define WRITE_ENABLE  1'b1
`define WRITE_DISABLE 1'b0
`endif

package regfile_wb_pkg;
    localparam int DATA_W     = `DATA_WIDTH;
    localparam int RADDR_W    = `RADDR_WIDTH;
    localparam int REG_NUM    = `REG_NUM;
    localparam int PEND_DEPTH = 2;
endpackage

// File: rtl/regfile_pend_q.sv
// Pending memory-write FIFO with per-entry live bits, kill-by-address and
// two associative lookup ports used for read bypass.
module regfile_pend_q
    import regfile_wb_pkg::*;
#(
    parameter int DW    = DATA_W,
    parameter int AW    = RADDR_W,
    parameter int DEPTH = PEND_DEPTH
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          enq,
    input  logic [AW-1:0] enq_addr,
    input  logic [DW-1:0] enq_data,
    input  logic          deq,
    input  logic          kill,
    input  logic [AW-1:0] kill_addr,
    input  logic [AW-1:0] look_addr1,
    input  logic [AW-1:0] look_addr2,
    output logic          full,
    output logic          empty,
    output logic          head_live,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic          hit1,
    output logic [DW-1:0] hit_data1,
    output logic          hit2,
    output logic [DW-1:0] hit_data2
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]    head_reg, tail_reg;
    logic [AW-1:0]  addr_mem [DEPTH];
    logic [DW-1:0]  data_mem [DEPTH];
    logic [DEPTH-1:0] live_reg;

    wire [PW-1:0] head_idx = head_reg[PW-1:0];
    wire [PW-1:0] tail_idx = tail_reg[PW-1:0];

    assign empty     = (head_reg == tail_reg);
    assign full      = (head_reg[PW] != tail_reg[PW]) && (head_idx == tail_idx);
    assign head_live = live_reg[head_idx];
    assign head_addr = addr_mem[head_idx];
    assign head_data = data_mem[head_idx];

    always_ff @(posedge clk) begin
        if (srst) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            if (enq) begin
                addr_mem[tail_idx] <= enq_addr;
                data_mem[tail_idx] <= enq_data;
                tail_reg           <= tail_reg + 1'b1;
            end
            if (deq)
                head_reg <= head_reg + 1'b1;
        end
    end

    // Live is cleared on dequeue, so a set live bit also means the slot is occupied.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_live
            always_ff @(posedge clk) begin
                if (srst)
                    live_reg[gi] <= 1'b0;
                else if (enq && tail_idx == PW'(gi))
                    live_reg[gi] <= 1'b1;
                else if ((deq && head_idx == PW'(gi)) ||
                         (kill && addr_mem[gi] == kill_addr) ||
                         (enq && addr_mem[gi] == enq_addr))
                    live_reg[gi] <= 1'b0;
            end
        end
    endgenerate

    // At most one live entry per register, so OR-merging the matches is exact.
    always_comb begin
        hit1      = 1'b0;
        hit2      = 1'b0;
        hit_data1 = '0;
        hit_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_reg[i] && addr_mem[i] == look_addr1) begin
                hit1      = 1'b1;
                hit_data1 = hit_data1 | data_mem[i];
            end
            if (live_reg[i] && addr_mem[i] == look_addr2) begin
                hit2      = 1'b1;
                hit_data2 = hit_data2 | data_mem[i];
            end
        end
    end
endmodule

// File: rtl/regfile_wb.sv
// Integer register file with one write port shared by execute and memory writeback;
// losing memory writes wait in a small queue and are bypassed to both read ports.
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_W,
    parameter int RADDR_WIDTH = RADDR_W,
    parameter int PEND_DEPTH  = regfile_wb_pkg::PEND_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   exe_we_i,
    input  logic [RADDR_WIDTH-1:0] exe_waddr_i,
    input  logic [DATA_WIDTH-1:0]  exe_wdata_i,
    input  logic                   mem_valid_i,
    output logic                   mem_ready_o,
    input  logic [RADDR_WIDTH-1:0] mem_waddr_i,
    input  logic [DATA_WIDTH-1:0]  mem_wdata_i,
    input  logic [RADDR_WIDTH-1:0] raddr1_i,
    output logic [DATA_WIDTH-1:0]  rdata1_o,
    input  logic [RADDR_WIDTH-1:0] raddr2_i,
    output logic [DATA_WIDTH-1:0]  rdata2_o,
    output logic                   pend_busy_o
);
    localparam int NREG = 1 << RADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_reg [NREG];

    logic                   q_full, q_empty, head_live;
    logic [RADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0]  head_data;
    logic                   hit [2];
    logic [DATA_WIDTH-1:0]  hit_data [2];
    logic [RADDR_WIDTH-1:0] raddr [2];
    logic [DATA_WIDTH-1:0]  rdata [2];

    wire exe_wr   = exe_we_i && (exe_waddr_i != '0);
    wire mem_xfer = mem_valid_i && mem_ready_o;
    // Memory is older than execute, so a same-cycle execute write to the same register wins outright.
    wire mem_drop = (mem_waddr_i == '0) || (exe_wr && exe_waddr_i == mem_waddr_i);
    wire mem_keep = mem_xfer && !mem_drop;
    wire deq      = !exe_wr && !q_empty;
    wire mem_dir  = mem_keep && !exe_wr && q_empty;
    wire enq      = mem_keep && !mem_dir;

    assign mem_ready_o = !rst_i && !q_full;
    assign pend_busy_o = !rst_i && !q_empty;

    regfile_pend_q #(
        .DW    (DATA_WIDTH),
        .AW    (RADDR_WIDTH),
        .DEPTH (PEND_DEPTH)
    ) u_pend_q (
        .clk        (clk_i),
        .srst       (rst_i),
        .enq        (enq),
        .enq_addr   (mem_waddr_i),
        .enq_data   (mem_wdata_i),
        .deq        (deq),
        .kill       (exe_wr),
        .kill_addr  (exe_waddr_i),
        .look_addr1 (raddr1_i),
        .look_addr2 (raddr2_i),
        .full       (q_full),
        .empty      (q_empty),
        .head_live  (head_live),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .hit1       (hit[0]),
        .hit_data1  (hit_data[0]),
        .hit2       (hit[1]),
        .hit_data2  (hit_data[1])
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++)
                regs_reg[i] <= '0;
        end else if (exe_wr) begin
            regs_reg[exe_waddr_i] <= exe_wdata_i;
        end else if (deq) begin
            if (head_live)
                regs_reg[head_addr] <= head_data;
        end else if (mem_dir) begin
            regs_reg[mem_waddr_i] <= mem_wdata_i;
        end
    end

    assign raddr[0] = raddr1_i;
    assign raddr[1] = raddr2_i;
    assign rdata1_o = rdata[0];
    assign rdata2_o = rdata[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                rdata[gi] = regs_reg[raddr[gi]];
                if (rst_i || raddr[gi] == '0)
                    rdata[gi] = '0;
                else if (exe_wr && exe_waddr_i == raddr[gi])
                    rdata[gi] = exe_wdata_i;
                else if (mem_keep && mem_waddr_i == raddr[gi])
                    rdata[gi] = mem_wdata_i;
                else if (hit[gi])
                    rdata[gi] = hit_data[gi];
            end
        end
    endgenerate
endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: arbitration, pending queue, kill and bypass.
module tb_regfile_wb;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        exe_we_i;
    logic [4:0]  exe_waddr_i;
    logic [31:0] exe_wdata_i;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic [4:0]  mem_waddr_i;
    logic [31:0] mem_wdata_i;
    logic [4:0]  raddr1_i, raddr2_i;
    logic [31:0] rdata1_o, rdata2_o;
    logic        pend_busy_o;

    int checks = 0;
    int errors = 0;

    regfile_wb dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .exe_we_i    (exe_we_i),
        .exe_waddr_i (exe_waddr_i),
        .exe_wdata_i (exe_wdata_i),
        .mem_valid_i (mem_valid_i),
        .mem_ready_o (mem_ready_o),
        .mem_waddr_i (mem_waddr_i),
        .mem_wdata_i (mem_wdata_i),
        .raddr1_i    (raddr1_i),
        .rdata1_o    (rdata1_o),
        .raddr2_i    (raddr2_i),
        .rdata2_o    (rdata2_o),
        .pend_busy_o (pend_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        exe_we_i = 1'b0; exe_waddr_i = '0; exe_wdata_i = '0;
        mem_valid_i = 1'b0; mem_waddr_i = '0; mem_wdata_i = '0;
    endtask

    task automatic drive(input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic [4:0] r1, input logic [4:0] r2);
        exe_we_i = ew; exe_waddr_i = ea; exe_wdata_i = ed;
        mem_valid_i = mv; mem_waddr_i = ma; mem_wdata_i = md;
        raddr1_i = r1; raddr2_i = r2;
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h1, 5'd5, 5'd6);
        tick(); tick();
        checks++; if (mem_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", mem_ready_o); end
        checks++; if (pend_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", pend_busy_o); end
        checks++; if (rdata1_o !== 32'h0) begin errors++; $display("FAIL reset_rdata1 got=%h exp=0", rdata1_o); end
        rst_i = 1'b0;
        idle();
        tick();
        for (int r = 1; r < 32; r++) begin
            raddr1_i = 5'(r); raddr2_i = 5'(32 - r);
            #1;
            checks++; if (rdata1_o !== 32'h0) begin errors++; $display("FAIL reset_clear1 x%0d got=%h exp=0", r, rdata1_o); end
            checks++; if (rdata2_o !== 32'h0) begin errors++; $display("FAIL reset_clear2 x%0d got=%h exp=0", 32 - r, rdata2_o); end
        end
        checks++; if (mem_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b exp=1", mem_ready_o); end
    endtask

    task automatic test_basic();
        drive(1'b1, 5'd5, 32'h11111111, 1'b1, 5'd6, 32'hA5A5A5A5, 5'd5, 5'd6);
        checks++; if (mem_ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready got=%b exp=1", mem_ready_o); end
        checks++; if (rdata1_o !== 32'h11111111) begin errors++; $display("FAIL basic_exe_bypass got=%h exp=11111111", rdata1_o); end
        checks++; if (rdata2_o !== 32'hA5A5A5A5) begin errors++; $display("FAIL basic_mem_bypass got=%h exp=a5a5a5a5", rdata2_o); end
        tick();
        idle(); #1;
        checks++; if (pend_busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", pend_busy_o); end
        checks++; if (rdata2_o !== 32'hA5A5A5A5) begin errors++; $display("FAIL basic_queue_bypass got=%h exp=a5a5a5a5", rdata2_o); end
        tick();
        checks++; if (pend_busy_o !== 1'b0) begin errors++; $display("FAIL basic_drained got=%b exp=0", pend_busy_o); end
        checks++; if (rdata2_o !== 32'hA5A5A5A5) begin errors++; $display("FAIL basic_x6_array got=%h exp=a5a5a5a5", rdata2_o); end
        checks++; if (rdata1_o !== 32'h11111111) begin errors++; $display("FAIL basic_x5_array got=%h exp=11111111", rdata1_o); end
    endtask

    task automatic test_full();
        drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd7, 32'd1, 5'd7, 5'd8);
        checks++; if (mem_ready_o !== 1'b1) begin errors++; $display("FAIL full_push1_ready got=%b exp=1", mem_ready_o); end
        tick();
        drive(1'b1, 5'd20, 32'h21, 1'b1, 5'd8, 32'd2, 5'd7, 5'd8);
        checks++; if (mem_ready_o !== 1'b1) begin errors++; $display("FAIL full_push2_ready got=%b exp=1", mem_ready_o); end
        tick();
        drive(1'b1, 5'd20, 32'h22, 1'b1, 5'd11, 32'd3, 5'd7, 5'd8);
        checks++; if (mem_ready_o !== 1'b0) begin errors++; $display("FAIL full_push3_ready got=%b exp=0", mem_ready_o); end
        checks++; if (rdata1_o !== 32'd1 || rdata2_o !== 32'd2) begin errors++; $display("FAIL full_bypass got=%h/%h exp=1/2", rdata1_o, rdata2_o); end
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd11, 5'd20);
        checks++; if (rdata1_o !== 32'h0) begin errors++; $display("FAIL full_x11_rejected got=%h exp=0", rdata1_o); end
        checks++; if (rdata2_o !== 32'h22) begin errors++; $display("FAIL full_x20 got=%h exp=22", rdata2_o); end
        tick();
        checks++; if (pend_busy_o !== 1'b1 || mem_ready_o !== 1'b1) begin errors++; $display("FAIL full_drain1 busy=%b ready=%b exp=1/1", pend_busy_o, mem_ready_o); end
        tick();
        raddr1_i = 5'd7; raddr2_i = 5'd8; #1;
        checks++; if (pend_busy_o !== 1'b0) begin errors++; $display("FAIL full_drain2 busy=%b exp=0", pend_busy_o); end
        checks++; if (rdata1_o !== 32'd1 || rdata2_o !== 32'd2) begin errors++; $display("FAIL full_array got=%h/%h exp=1/2", rdata1_o, rdata2_o); end
    endtask

    task automatic test_kill();
        drive(1'b1, 5'd21, 32'h7, 1'b1, 5'd9, 32'hDEAD, 5'd9, 5'd21);
        checks++; if (rdata1_o !== 32'hDEAD) begin errors++; $display("FAIL kill_mem_bypass got=%h exp=dead", rdata1_o); end
        tick();
        drive(1'b1, 5'd9, 32'hBEEF, 1'b0, 5'd0, 32'h0, 5'd9, 5'd21);
        checks++; if (rdata1_o !== 32'hBEEF) begin errors++; $display("FAIL kill_exe_bypass got=%h exp=beef", rdata1_o); end
        tick();
        idle(); #1;
        checks++; if (pend_busy_o !== 1'b1) begin errors++; $display("FAIL kill_busy got=%b exp=1", pend_busy_o); end
        checks++; if (rdata1_o !== 32'hBEEF) begin errors++; $display("FAIL kill_killed_entry got=%h exp=beef", rdata1_o); end
        tick();
        checks++; if (pend_busy_o !== 1'b0) begin errors++; $display("FAIL kill_drained got=%b exp=0", pend_busy_o); end
        checks++; if (rdata1_o !== 32'hBEEF) begin errors++; $display("FAIL kill_final got=%h exp=beef", rdata1_o); end
    endtask

    task automatic test_same_addr();
        drive(1'b1, 5'd10, 32'd3, 1'b1, 5'd10, 32'd4, 5'd10, 5'd10);
        checks++; if (mem_ready_o !== 1'b1) begin errors++; $display("FAIL same_ready got=%b exp=1", mem_ready_o); end
        checks++; if (rdata1_o !== 32'd3) begin errors++; $display("FAIL same_bypass got=%h exp=3", rdata1_o); end
        tick();
        idle(); #1;
        checks++; if (pend_busy_o !== 1'b0) begin errors++; $display("FAIL same_not_queued got=%b exp=0", pend_busy_o); end
        checks++; if (rdata2_o !== 32'd3) begin errors++; $display("FAIL same_array got=%h exp=3", rdata2_o); end
    endtask

    task automatic test_x0();
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0);
        checks++; if (rdata1_o !== 32'h0 || rdata2_o !== 32'h0) begin errors++; $display("FAIL x0_bypass got=%h/%h exp=0/0", rdata1_o, rdata2_o); end
        checks++; if (mem_ready_o !== 1'b1) begin errors++; $display("FAIL x0_ready got=%b exp=1", mem_ready_o); end
        tick();
        idle(); #1;
        checks++; if (pend_busy_o !== 1'b0) begin errors++; $display("FAIL x0_busy got=%b exp=0", pend_busy_o); end
        checks++; if (rdata1_o !== 32'h0) begin errors++; $display("FAIL x0_array got=%h exp=0", rdata1_o); end
    endtask

    task automatic test_direct();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'h55, 5'd14, 5'd0);
        checks++; if (rdata1_o !== 32'h55) begin errors++; $display("FAIL direct_bypass got=%h exp=55", rdata1_o); end
        tick();
        idle(); #1;
        checks++; if (pend_busy_o !== 1'b0) begin errors++; $display("FAIL direct_busy got=%b exp=0", pend_busy_o); end
        checks++; if (rdata1_o !== 32'h55) begin errors++; $display("FAIL direct_array got=%h exp=55", rdata1_o); end
    endtask

    task automatic test_reset_pending();
        drive(1'b1, 5'd22, 32'd5, 1'b1, 5'd12, 32'h77, 5'd12, 5'd22);
        tick();
        drive(1'b1, 5'd23, 32'd6, 1'b1, 5'd13, 32'h88, 5'd12, 5'd13);
        tick();
        idle(); #1;
        checks++; if (pend_busy_o !== 1'b1 || mem_ready_o !== 1'b0) begin errors++; $display("FAIL rstq_full busy=%b ready=%b exp=1/0", pend_busy_o, mem_ready_o); end
        rst_i = 1'b1; #1;
        checks++; if (pend_busy_o !== 1'b0 || mem_ready_o !== 1'b0 || rdata1_o !== 32'h0) begin errors++; $display("FAIL rstq_during busy=%b ready=%b rd1=%h exp=0/0/0", pend_busy_o, mem_ready_o, rdata1_o); end
        tick();
        rst_i = 1'b0; #1;
        checks++; if (pend_busy_o !== 1'b0 || mem_ready_o !== 1'b1) begin errors++; $display("FAIL rstq_empty busy=%b ready=%b exp=0/1", pend_busy_o, mem_ready_o); end
        checks++; if (rdata1_o !== 32'h0 || rdata2_o !== 32'h0) begin errors++; $display("FAIL rstq_regs got=%h/%h exp=0/0", rdata1_o, rdata2_o); end
        raddr1_i = 5'd22; raddr2_i = 5'd5; #1;
        checks++; if (rdata1_o !== 32'h0 || rdata2_o !== 32'h0) begin errors++; $display("FAIL rstq_regs2 got=%h/%h exp=0/0", rdata1_o, rdata2_o); end
        tick();
        checks++; if (rdata1_o !== 32'h0 || rdata2_o !== 32'h0) begin errors++; $display("FAIL rstq_no_drain got=%h/%h exp=0/0", rdata1_o, rdata2_o); end
    endtask

    initial begin
        idle();
        raddr1_i = '0; raddr2_i = '0;
        rst_i = 1'b1;
        test_reset();
        test_basic();
        test_full();
        test_kill();
        test_same_addr();
        test_x0();
        test_direct();
        test_reset_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
